// File: rtl/button_bus_master.sv
// Bus initiator for the FPGA peripheral read bus: issues host reads, auto-reads
// the interrupt status address on each fpga_int rising edge, and reports each read as a one-cycle pulse.
module button_bus_master #(
  parameter int                DATA_W     = 24,
  parameter int                ADDR_W     = 2,
  parameter logic [ADDR_W-1:0] INT_ADDR   = '0,
  parameter int                TIMEOUT    = 1024,
  parameter int                GAP_CYCLES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  input  logic [ADDR_W-1:0] req_addr,
  output logic              req_ready,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_data,
  output logic [ADDR_W-1:0] rsp_addr,
  output logic              rsp_int,
  output logic              rsp_timeout,
  output logic              fpga_ce,
  output logic [ADDR_W-1:0] fpga_addr,
  input  logic [DATA_W-1:0] fpga_data,
  input  logic              fpga_drdy,
  input  logic              fpga_int
);

  localparam int TCNT_W = $clog2(TIMEOUT + 1);
  localparam int GCNT_W = $clog2(GAP_CYCLES + 1);
  localparam logic [TCNT_W-1:0] TCNT_LAST = TCNT_W'(TIMEOUT - 1);
  localparam logic [GCNT_W-1:0] GCNT_LAST = GCNT_W'(GAP_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, WAIT, GAP} state_t;

  state_t              state_reg, state_next;
  logic                int_q_reg, int_q_next;
  logic                int_pending_reg, int_pending_next;
  logic                src_int_reg, src_int_next;
  logic [TCNT_W-1:0]   tcnt_reg, tcnt_next;
  logic [GCNT_W-1:0]   gcnt_reg, gcnt_next;
  logic                fpga_ce_reg, fpga_ce_next;
  logic [ADDR_W-1:0]   fpga_addr_reg, fpga_addr_next;
  logic                req_ready_reg, req_ready_next;
  logic                rsp_valid_reg, rsp_valid_next;
  logic [DATA_W-1:0]   rsp_data_reg, rsp_data_next;
  logic [ADDR_W-1:0]   rsp_addr_reg, rsp_addr_next;
  logic                rsp_int_reg, rsp_int_next;
  logic                rsp_timeout_reg, rsp_timeout_next;
  logic                int_rise;
  logic                take_int;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg       <= IDLE;
      int_q_reg       <= 1'b0;
      int_pending_reg <= 1'b0;
      src_int_reg     <= 1'b0;
      tcnt_reg        <= '0;
      gcnt_reg        <= '0;
      fpga_ce_reg     <= 1'b0;
      fpga_addr_reg   <= '0;
      req_ready_reg   <= 1'b0;
      rsp_valid_reg   <= 1'b0;
      rsp_data_reg    <= '0;
      rsp_addr_reg    <= '0;
      rsp_int_reg     <= 1'b0;
      rsp_timeout_reg <= 1'b0;
    end else begin
      state_reg       <= state_next;
      int_q_reg       <= int_q_next;
      int_pending_reg <= int_pending_next;
      src_int_reg     <= src_int_next;
      tcnt_reg        <= tcnt_next;
      gcnt_reg        <= gcnt_next;
      fpga_ce_reg     <= fpga_ce_next;
      fpga_addr_reg   <= fpga_addr_next;
      req_ready_reg   <= req_ready_next;
      rsp_valid_reg   <= rsp_valid_next;
      rsp_data_reg    <= rsp_data_next;
      rsp_addr_reg    <= rsp_addr_next;
      rsp_int_reg     <= rsp_int_next;
      rsp_timeout_reg <= rsp_timeout_next;
    end
  end

  always_comb begin
    state_next       = state_reg;
    src_int_next     = src_int_reg;
    tcnt_next        = tcnt_reg;
    gcnt_next        = gcnt_reg;
    fpga_ce_next     = fpga_ce_reg;
    fpga_addr_next   = fpga_addr_reg;
    rsp_valid_next   = 1'b0;
    rsp_data_next    = rsp_data_reg;
    rsp_addr_next    = rsp_addr_reg;
    rsp_int_next     = rsp_int_reg;
    rsp_timeout_next = rsp_timeout_reg;
    take_int         = 1'b0;
    int_rise         = fpga_int & ~int_q_reg;
    int_q_next       = fpga_int;

    case (state_reg)
      IDLE: begin
        if (int_pending_reg) begin
          fpga_addr_next = INT_ADDR;
          src_int_next   = 1'b1;
          fpga_ce_next   = 1'b1;
          tcnt_next      = '0;
          take_int       = 1'b1;
          state_next     = WAIT;
        end else if (req_valid && req_ready_reg) begin
          fpga_addr_next = req_addr;
          src_int_next   = 1'b0;
          fpga_ce_next   = 1'b1;
          tcnt_next      = '0;
          state_next     = WAIT;
        end
      end
      WAIT: begin
        // Data on the last allowed cycle wins over the timeout.
        if (fpga_drdy || tcnt_reg == TCNT_LAST) begin
          rsp_valid_next   = 1'b1;
          rsp_data_next    = fpga_drdy ? fpga_data : '0;
          rsp_timeout_next = ~fpga_drdy;
          rsp_addr_next    = fpga_addr_reg;
          rsp_int_next     = src_int_reg;
          fpga_ce_next     = 1'b0;
          gcnt_next        = '0;
          state_next       = GAP;
        end else begin
          tcnt_next = tcnt_reg + 1'b1;
        end
      end
      GAP: begin
        if (gcnt_reg == GCNT_LAST) begin
          state_next = IDLE;
        end else begin
          gcnt_next = gcnt_reg + 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase

    // A fresh edge arriving while the previous interrupt is being taken stays pending.
    int_pending_next = int_rise | (int_pending_reg & ~take_int);
    req_ready_next   = (state_next == IDLE) & ~int_pending_next;
  end

  assign req_ready   = req_ready_reg;
  assign rsp_valid   = rsp_valid_reg;
  assign rsp_data    = rsp_data_reg;
  assign rsp_addr    = rsp_addr_reg;
  assign rsp_int     = rsp_int_reg;
  assign rsp_timeout = rsp_timeout_reg;
  assign fpga_ce     = fpga_ce_reg;
  assign fpga_addr   = fpga_addr_reg;

endmodule
